// File: rtl/count_display_driver.sv
// Stopwatch count display: shift-add-3 binary-to-BCD conversion feeding a
// multiplexed, active-low 4-digit seven-segment scan with leading-zero blanking.
//
// state | meaning
// IDLE  | waiting for count to differ from the last converted value
// SHIFT | eight adjust-and-shift steps of the double-dabble loop
// DONE  | publish the converted digits and drop busy
module count_display_driver #(
    parameter int REFRESH_DIV = 5000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  count,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  bin_last;
    logic [7:0]  bin_sr;
    logic [11:0] bcd_work;
    logic [11:0] bcd_adj;
    logic [2:0]  iter;
    logic        load, shift_en, publish;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    nib;
    logic          lit;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != bin_last) state_next = SHIFT;
            SHIFT:   if (iter == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        publish  = 1'b0;
        case (state)
            IDLE:    load = (count != bin_last);
            SHIFT:   shift_en = 1'b1;
            DONE:    publish = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < 3; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
    end

    // bcd only changes in DONE, so a half-converted value is never visible
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_last <= 8'd0;
            bin_sr   <= 8'd0;
            bcd_work <= 12'h000;
            iter     <= 3'd0;
            bcd      <= 12'h000;
            busy     <= 1'b0;
        end else begin
            if (load) begin
                bin_sr   <= count;
                bin_last <= count;
                bcd_work <= 12'h000;
                iter     <= 3'd0;
                busy     <= 1'b1;
            end
            if (shift_en) begin
                {bcd_work, bin_sr} <= {bcd_adj[10:0], bin_sr, 1'b0};
                iter               <= iter + 3'd1;
            end
            if (publish) begin
                bcd  <= bcd_work;
                busy <= 1'b0;
            end
        end
    end

    always_comb begin
        nib = bcd[3:0];
        lit = 1'b1;
        case (digit_idx)
            2'd0: nib = bcd[3:0];
            2'd1: begin
                nib = bcd[7:4];
                lit = !(BLANK_LZ && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0);
            end
            2'd2: begin
                nib = bcd[11:8];
                lit = !(BLANK_LZ && bcd[11:8] == 4'd0);
            end
            default: lit = 1'b0;
        endcase
        an_next  = lit ? ~(4'b0001 << digit_idx) : 4'b1111;
        seg_next = lit ? seg_code(nib) : 7'b1111111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            an          <= 4'b1110;
            seg         <= 7'b1000000;
        end else begin
            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized bench for count_display_driver: two instances (blanking on/off)
// checked every cycle against a decimal-arithmetic model of conversion and scan.
module tb_count_display_driver;

    localparam int R = 4;

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  count = 8'd0;
    logic [11:0] bcd1, bcd0;
    logic        busy1, busy0;
    logic [3:0]  an1, an0;
    logic [6:0]  seg1, seg0;
    logic        dp1, dp0;

    count_display_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) dut_blz (
        .clk(clk), .reset(reset), .count(count),
        .bcd(bcd1), .busy(busy1), .an(an1), .seg(seg1), .dp(dp1)
    );

    count_display_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b0)) dut_full (
        .clk(clk), .reset(reset), .count(count),
        .bcd(bcd0), .busy(busy0), .an(an0), .seg(seg0), .dp(dp0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Returns {an, seg} for digit slot idx showing the decimal value held in b.
    function automatic logic [10:0] disp(input int idx, input logic [11:0] b, input bit blz);
        int v;
        int d;
        bit show;
        logic [3:0] a;
        v = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
        d = (idx == 0) ? int'(b[3:0]) : (idx == 1) ? int'(b[7:4]) : int'(b[11:8]);
        show = (idx == 0) || (idx < 3 && (!blz || v >= ((idx == 1) ? 10 : 100)));
        if (!show) return {4'b1111, 7'b1111111};
        a = 4'b1111;
        a[idx] = 1'b0;
        return {a, (d <= 9) ? SEG_TBL[d] : 7'b1111111};
    endfunction

    int          m_edges;
    int          m_busy_cnt;
    logic [7:0]  m_last, m_val;
    logic [11:0] m_bcd;
    logic        m_busy;
    logic [3:0]  e_an1, e_an0;
    logic [6:0]  e_seg1, e_seg0;

    // Conversion modelled as a 9-cycle job; scan slot derived from elapsed cycles.
    always @(posedge clk) begin
        if (reset) begin
            m_edges    = 0;
            m_busy_cnt = 0;
            m_last     = 8'd0;
            m_val      = 8'd0;
            m_bcd      = 12'h000;
            m_busy     = 1'b0;
            e_an1      = 4'b1110;
            e_seg1     = 7'b1000000;
            e_an0      = 4'b1110;
            e_seg0     = 7'b1000000;
        end else begin
            {e_an1, e_seg1} = disp((m_edges / R) % 4, m_bcd, 1'b1);
            {e_an0, e_seg0} = disp((m_edges / R) % 4, m_bcd, 1'b0);
            m_edges++;
            if (m_busy_cnt == 0) begin
                if (count != m_last) begin
                    m_last     = count;
                    m_val      = count;
                    m_busy_cnt = 9;
                    m_busy     = 1'b1;
                end
            end else begin
                m_busy_cnt--;
                if (m_busy_cnt == 0) begin
                    m_bcd  = to_bcd(int'(m_val));
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("bcd_blz", bcd1, m_bcd);
            check_eq("busy_blz", busy1, m_busy);
            check_eq("an_blz", an1, e_an1);
            check_eq("seg_blz", seg1, e_seg1);
            check_eq("dp_blz", dp1, 1'b1);
            check_eq("bcd_full", bcd0, m_bcd);
            check_eq("busy_full", busy0, m_busy);
            check_eq("an_full", an0, e_an0);
            check_eq("seg_full", seg0, e_seg0);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        count = 8'd0;
        hold(2);
        chk_en = 1'b1;
        reset = 1'b0;
        hold(20);
        check_eq("idle_zero", bcd1, 12'h000);

        count = 8'd255;
        hold(40);
        check_eq("conv_255", bcd1, 12'h255);

        count = 8'd7;
        hold(40);
        check_eq("conv_7", bcd1, 12'h007);

        count = 8'd100;
        hold(3);
        count = 8'd200;
        hold(30);
        check_eq("conv_200", bcd1, 12'h200);

        count = 8'd128;
        hold(4);
        reset = 1'b1;
        hold(1);
        check_eq("rst_abort", bcd1, 12'h000);
        reset = 1'b0;
        hold(15);
        check_eq("conv_128", bcd1, 12'h128);

        count = 8'd10;
        hold(40);
        check_eq("conv_10", bcd1, 12'h010);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       count = 8'($urandom_range(0, 9));
                1:       count = 8'($urandom_range(10, 99));
                default: count = 8'($urandom_range(0, 255));
            endcase
            hold($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                hold($urandom_range(1, 2));
                reset = 1'b0;
            end
        end
        hold(40);
        check_eq("final_conv", bcd1, to_bcd(int'(count)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
